// File: rtl/pc_gen_unit.sv
// Registered next-PC generator: owns the fetch PC, resolves RV64I branch/jump
// redirects from execute, traps misaligned targets and handles ebreak halt/restart.
//
// state | meaning
// BOOT  | out of reset, fetch_valid low, waits for the first enabled edge
// RUN   | presenting fetch_pc, advancing on handshake or redirect
// HALT  | stopped by ebreak, waits for restart
module pc_gen_unit #(
    parameter int              XLEN           = 64,
    parameter logic [XLEN-1:0] RESET_PC       = 64'h8000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC       = 64'h8000_0000,
    parameter int              IALIGN         = 32,
    parameter int              HALT_ON_EBREAK = 1,
    parameter int              CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  fetch_pc,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             br_en,
    input  logic [2:0]       br_funct3,
    input  logic [XLEN-1:0]  br_rs1,
    input  logic [XLEN-1:0]  br_rs2,
    input  logic             jump,
    input  logic             jalr,
    input  logic [XLEN-1:0]  jalr_base,
    input  logic [XLEN-1:0]  imm,
    input  logic             ebreak,
    input  logic             restart,
    output logic             flush,
    output logic             halted,
    output logic             exc_valid,
    output logic [XLEN-1:0]  exc_tval,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            flush_q;
    logic            exc_q;

    logic            br_taken;
    logic [XLEN-1:0] rel_tgt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] redir_tgt;
    logic            redir;
    logic            misaligned;

    always_comb begin
        br_taken = 1'b0;
        case (br_funct3)
            3'b000:  br_taken = (br_rs1 == br_rs2);
            3'b001:  br_taken = (br_rs1 != br_rs2);
            3'b100:  br_taken = ($signed(br_rs1) <  $signed(br_rs2));
            3'b101:  br_taken = ($signed(br_rs1) >= $signed(br_rs2));
            3'b110:  br_taken = (br_rs1 <  br_rs2);
            3'b111:  br_taken = (br_rs1 >= br_rs2);
            default: br_taken = 1'b0;
        endcase
    end

    assign rel_tgt   = ex_pc + imm;
    assign jalr_sum  = jalr_base + imm;
    assign jalr_tgt  = {jalr_sum[XLEN-1:1], 1'b0};
    // A taken branch outranks a jump asserted in the same cycle.
    assign redir     = (br_en && br_taken) || jump;
    assign redir_tgt = (br_en && br_taken) ? rel_tgt : (jalr ? jalr_tgt : rel_tgt);
    assign misaligned = (IALIGN == 16) ? redir_tgt[0] : (redir_tgt[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            flush_q      <= 1'b0;
            exc_q        <= 1'b0;
            exc_tval     <= '0;
            redirect_cnt <= '0;
        end else if (ena) begin
            flush_q <= 1'b0;
            exc_q   <= 1'b0;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (ex_valid && ebreak) begin
                        flush_q <= 1'b1;
                        if (HALT_ON_EBREAK != 0) state <= HALT;
                        else                     pc    <= RESET_PC;
                    end else if (ex_valid && redir) begin
                        flush_q <= 1'b1;
                        if (misaligned) begin
                            pc       <= TRAP_VEC;
                            exc_q    <= 1'b1;
                            exc_tval <= redir_tgt;
                        end else begin
                            pc           <= redir_tgt;
                            redirect_cnt <= redirect_cnt + CNT_W'(1);
                        end
                    end else if (fetch_ready) begin
                        pc <= pc + XLEN'(4);
                    end
                end
                HALT: begin
                    if (restart) begin
                        pc      <= RESET_PC;
                        state   <= RUN;
                        flush_q <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Pulses are masked while frozen so a held pulse register is not seen twice.
    assign flush       = flush_q & ena;
    assign exc_valid   = exc_q & ena;
    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign fetch_pc    = pc;

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parameterised, registered next-PC generator that replaces the combinational next-PC mux. It holds the architectural fetch PC and presents it to instruction fetch through a valid/ready handshake. It resolves full RV64I branch and jump redirects from execute, checks target alignment, and handles ebreak halt/restart. It also keeps a redirect performance counter.

Parameters:
XLEN, 64, PC and operand width
RESET_PC, 64'h8000_0000, PC loaded on reset and on restart from halt
TRAP_VEC, 64'h8000_0000, target for misaligned-target exceptions
IALIGN, 32, instruction alignment in bits (32: target[1:0] must be 0; 16: target[0] must be 0)
HALT_ON_EBREAK, 1, 1: ebreak enters HALT; 0: ebreak redirects to RESET_PC
CNT_W, 32, width of redirect_cnt

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ena  in  1  global run enable; 0 freezes all state
fetch_valid  out  1  fetch_pc is valid
fetch_ready  in  1  fetch accepts fetch_pc
fetch_pc  out  XLEN  current fetch address
ex_valid  in  1  execute-stage resolution inputs are valid this cycle
ex_pc  in  XLEN  PC of the resolving instruction
br_en  in  1  instruction is a conditional branch
br_funct3  in  3  000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
br_rs1, br_rs2  in  XLEN  branch compare operands
jump  in  1  jal or jalr
jalr  in  1  with jump: jalr; else jal
jalr_base  in  XLEN  rs1 value for jalr
imm  in  XLEN  sign-extended immediate
ebreak  in  1  ebreak retired
restart  in  1  leave HALT
flush  out  1  one-cycle pulse; downstream fetch/decode must discard in-flight instructions
halted  out  1  in HALT state
exc_valid  out  1  one-cycle pulse: misaligned target
exc_tval  out  XLEN  offending target, held until the next exception
redirect_cnt  out  CNT_W  count of taken redirects, wrapping

Behaviour:
- Reset (rst_n=0 at a clk edge): state=BOOT, pc=RESET_PC, fetch_valid=0, flush=0, halted=0, exc_valid=0, exc_tval=0, redirect_cnt=0.
- States:
  - BOOT: fetch_valid=0. Advances to RUN on the next edge with ena=1.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0, halted=1. With restart=1 and ena=1, pc<=RESET_PC, state<=RUN, flush pulses.
- ena=0: no register changes, including the counter. Outputs hold. Pulse outputs read 0.
- In RUN, the next-pc source is chosen by this priority, evaluated only when ex_valid=1:
  1. ebreak: HALT_ON_EBREAK=1 -> state<=HALT; otherwise pc<=RESET_PC. flush pulses in both cases.
  2. Taken branch: br_en=1 and the funct3 condition is true (signed compare for blt/bge, unsigned for bltu/bgeu). Target = ex_pc+imm.
  3. jal: jump=1, jalr=0. Target = ex_pc+imm.
  4. jalr: jump=1, jalr=1. Target = (jalr_base+imm) with bit 0 cleared.
  5. Otherwise, sequential.
- A redirect from cases 2–4 with an aligned target: pc<=target, flush=1 next cycle, redirect_cnt+=1.
- A misaligned target: pc<=TRAP_VEC, exc_valid=1, exc_tval<=target, flush=1. redirect_cnt is not incremented.
- Sequential advance: pc<=pc+4 only when fetch_valid&fetch_ready and no redirect. Otherwise pc holds; fetch_pc and fetch_valid stay stable while stalled.
- A redirect overrides a pending handshake in the same cycle. The accepted old pc is discarded by flush.
- All arithmetic is modulo 2^XLEN; the PC wraps from all-ones to 0. br_funct3 values 010/011 mean not taken.
- Latency: a redirect is visible on fetch_pc one cycle after ex_valid.
- Reset mid-operation has precedence over every other input.

Test Plan:
- Reset, ena=1, fetch_ready=1 for 3 cycles -> BOOT for 1 cycle; fetch_pc sequence 0x80000000, 0x80000004, 0x80000008; redirect_cnt=0.
- fetch_ready=0 for 4 cycles at pc 0x80000010 -> fetch_pc held at 0x80000010, fetch_valid=1 throughout.
- Branch decisions with ex_pc=0x80000020, imm=-16:
  - bltu, rs1=1, rs2=0xFFFF...FF -> taken; fetch_pc=0x80000010 next cycle; flush=1; redirect_cnt=1.
  - blt with the same operands -> not taken.
- jalr with jalr_base=0x80000101, imm=2 -> target 0x80000102 after bit-0 clear. IALIGN=32: exc_valid=1, exc_tval=0x80000102, fetch_pc=TRAP_VEC. IALIGN=16: redirect to 0x80000102.
- ebreak and jal in the same cycle (HALT_ON_EBREAK=1) -> HALT; halted=1; fetch_valid=0. restart -> fetch_pc=0x80000000.
- rst_n=0 asserted during a stall in HALT -> all outputs return to reset values on the next edge.
